// File: rtl/idex_alu_issue.sv
// ID/EX issue register: decodes ALU control, selects/extends operand B, and registers a
// valid-qualified bundle with stall/flush handling. Optional macro: IDEX_ORI_ZEXT_EN.
module idex_alu_issue #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  input  logic [15:0]      imm,
  input  logic             alu_src,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [2:0]       out_control,
  output logic             out_illegal,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [2:0] CTL_AND = 3'b000;
  localparam logic [2:0] CTL_OR  = 3'b001;
  localparam logic [2:0] CTL_ADD = 3'b010;
  localparam logic [2:0] CTL_SUB = 3'b110;
  localparam logic [2:0] CTL_SLT = 3'b111;

  // Returns {illegal, control}; unsupported encodings fall back to ADD.
  function automatic logic [3:0] decode_ctl(input logic [1:0] op, input logic [5:0] fn);
    logic [3:0] res;
    res = {1'b1, CTL_ADD};
    case (op)
      2'b00: res = {1'b0, CTL_ADD};
      2'b01: res = {1'b0, CTL_SUB};
      2'b10: begin
        case (fn)
          6'b100000: res = {1'b0, CTL_ADD};
          6'b100010: res = {1'b0, CTL_SUB};
          6'b100100: res = {1'b0, CTL_AND};
          6'b100101: res = {1'b0, CTL_OR};
          6'b101010: res = {1'b0, CTL_SLT};
          default:   res = {1'b1, CTL_ADD};
        endcase
      end
`ifdef IDEX_ORI_ZEXT_EN
      2'b11: res = {1'b0, CTL_OR};
`else
      2'b11: res = {1'b1, CTL_ADD};
`endif
      default: res = {1'b1, CTL_ADD};
    endcase
    return res;
  endfunction

  logic [3:0]       dec_s;
  logic [WIDTH-1:0] b_s;
  logic             valid_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [2:0]       ctl_r;
  logic             ill_r;
  logic [CNT_W-1:0] cnt_r;

  // Control decode and operand-B selection for the incoming slot
  always_comb begin
    dec_s = decode_ctl(alu_op, funct);
    b_s   = rd2;
`ifdef IDEX_ORI_ZEXT_EN
    if (alu_op == 2'b11) begin
      b_s = {{(WIDTH-16){1'b0}}, imm};
    end else if (alu_src) begin
      b_s = {{(WIDTH-16){imm[15]}}, imm};
    end else begin
      b_s = rd2;
    end
`else
    if (alu_src) begin
      b_s = {{(WIDTH-16){imm[15]}}, imm};
    end else begin
      b_s = rd2;
    end
`endif
  end

  // Issue bundle register: flush beats stall beats load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      ctl_r   <= CTL_ADD;
      ill_r   <= 1'b0;
    end else if (flush) begin
      valid_r <= 1'b0;
      ill_r   <= 1'b0;
    end else if (stall) begin
      valid_r <= valid_r;
    end else begin
      valid_r <= in_valid;
      if (in_valid) begin
        a_r   <= rd1;
        b_r   <= b_s;
        ctl_r <= dec_s[2:0];
        ill_r <= dec_s[3];
      end else begin
        ill_r <= 1'b0;
      end
    end
  end

  // Saturating count of edges that see an invalid bundle on the output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (!valid_r && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign in_ready    = ~stall;
  assign out_valid   = valid_r;
  assign out_a       = a_r;
  assign out_b       = b_r;
  assign out_control = ctl_r;
  assign out_illegal = ill_r;
  assign bubble_cnt  = cnt_r;

endmodule

// File: doc/idex_alu_issue.md
# idex_alu_issue

Execute-stage issue register for the MIPS pipeline: accepts a decoded instruction slot from the decode stage, translates `alu_op`/`funct` into the 3-bit ALU control code, selects and sign-extends the B operand, and presents a registered, valid-qualified operand/control bundle to the ALU one cycle later. It supports hazard-unit stall and branch flush, flags unsupported encodings, and keeps a saturating bubble counter for performance debug.

## Interface
- `WIDTH`, 32, operand width in bits.
- `CNT_W`, 16, bubble counter width in bits.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  decode slot holds an instruction.
- `in_ready`  out  1  stage accepts this cycle; equals `~stall`.
- `alu_op`  in  2  main-decoder ALU class.
- `funct`  in  6  R-type function field.
- `rd1`  in  WIDTH  register-file read 1.
- `rd2`  in  WIDTH  register-file read 2.
- `imm`  in  16  instruction immediate.
- `alu_src`  in  1  1 selects extended immediate for B.
- `stall`  in  1  hazard unit hold.
- `flush`  in  1  branch/jump squash.
- `out_valid`  out  1  bundle valid.
- `out_a`  out  WIDTH  ALU operand A.
- `out_b`  out  WIDTH  ALU operand B.
- `out_control`  out  3  ALU control code.
- `out_illegal`  out  1  unsupported encoding issued.
- `bubble_cnt`  out  CNT_W  saturating count of cycles with `out_valid`=0.

## Operation
- ALU control codes: ADD 010, SUB 110, AND 000, OR 001, SLT 111.
- Decode: `alu_op` 00 → ADD; 01 → SUB; 10 → by `funct`: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT; any other `funct` → illegal. `alu_op` 11: see Configuration.
- Illegal slot: `out_control`=010, `out_illegal`=1, `out_valid`=1, operands loaded normally. The slot is not dropped.
- B operand: `alu_src`=0 → `rd2`; `alu_src`=1 → `{{16{imm[15]}},imm}`. Zero extension applies only as described under Configuration.
- Register update priority each edge: `flush` > `stall` > load.
  - `flush`=1: `out_valid`←0 and `out_illegal`←0. Data fields are don't-care but hold their previous values.
  - Otherwise, `stall`=1: all outputs hold.
  - Otherwise: `out_valid`←`in_valid`. Data fields load only if `in_valid`=1. When `in_valid`=0, `out_illegal`←0.
- `bubble_cnt` increments on every edge where the registered `out_valid` is 0, including stall-held bubbles. It saturates at all ones and never wraps.

## Timing
- Reset values: `out_valid`=0, `out_a`=0, `out_b`=0, `out_control`=010, `out_illegal`=0, `bubble_cnt`=0. Reset is asynchronous and takes effect immediately, including mid-stall or mid-flush.
- Latency: inputs accepted at edge N appear on the outputs after edge N and remain through edge N+1 unless held.
- `in_ready` is combinational from `stall` only. No other input affects it.
- Simultaneous `flush` and `stall`: a bubble is inserted (flush wins). An upstream instruction offered in that cycle is not captured, and `in_ready`=0 still signals the hold.
- Back-to-back loads sustain one instruction per cycle with `stall`=0.
- The first edge after reset release with `in_valid`=0 increments `bubble_cnt` to 1.

## Configuration
- `IDEX_ORI_ZEXT_EN` defined:
  - `alu_op` 11 decodes to OR (001).
  - B is forced to `{16'b0,imm}` regardless of `alu_src`.
  - `out_illegal`=0 for this case.
- `IDEX_ORI_ZEXT_EN` undefined: `alu_op` 11 is illegal, handled as described in Operation (control 010, `out_illegal`=1).

## Test plan
- Reset: assert `rst` mid-run → all outputs take their reset values immediately. Release with `in_valid`=0 for 3 edges → `bubble_cnt`=3.
- R-type SLT: `alu_op`=10, `funct`=101010, `rd1`=5, `rd2`=9, `alu_src`=0 → next cycle `out_control`=111, `out_a`=5, `out_b`=9, `out_valid`=1.
- Immediate sign extension: `alu_op`=00, `alu_src`=1, `imm`=16'hFFFC → `out_b`=32'hFFFFFFFC, `out_control`=010.
- Stall, then flush: load ADD, then `stall`=1 for 2 cycles while inputs change → outputs unchanged and `in_ready`=0. Then `flush`=1 together with `stall`=1 → `out_valid`=0 next cycle.
- Illegal/config: `alu_op`=10, `funct`=000000 → `out_illegal`=1, `out_control`=010. `alu_op`=11, `imm`=16'h8001:
  - with `IDEX_ORI_ZEXT_EN` → `out_b`=32'h00008001, `out_control`=001, `out_illegal`=0.
  - without it → `out_illegal`=1.
- Saturation: `CNT_W`=4, idle 20 cycles → `bubble_cnt`=15 and holds.
